myip_i2s_sender_v1_0: RTL and testbench
=======================================

MYIP_I2S_SENDER_V1_0 -- requirements
Module: myip_i2s_sender_v1_0

Interface
REQ-001 The module SHALL provide parameter I2S_RECEIVER_NUM, default 16: number of identical I2S output lanes N (N >= 1).
REQ-002 The module SHALL provide parameter I2S_SENDER_TEST_DATA_WIDTH, default 24: sample word width W (1 <= W <= 31).
REQ-003 The module SHALL provide parameter BCLK_DIV, default 4: clk cycles per bclk period (even, >= 2).
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The module SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port i2s_sender_bclk, output, N bits: bit clock per lane.
REQ-008 The module SHALL have port i2s_sender_lrclk, output, N bits: word select per lane (0 = left, 1 = right).
REQ-009 The module SHALL have port i2s_sender_sdata, output, N bits: serial data per lane.
REQ-010 The module SHALL have port data_source, output, W bits: frame sequence value that seeds the current frame's samples.

Function
REQ-011 All N lanes SHALL share the same bclk and lrclk timing; bit k of each clock bus is a copy of the common signal.
REQ-012 A divider SHALL count 0..BCLK_DIV/2-1; on the terminal count bclk toggles and the divider returns to 0, so bclk period = BCLK_DIV clk cycles at 50% duty.
REQ-013 On each bclk 1->0 toggle edge (falling edge), the bit counter SHALL advance modulo 64; in the same clk edge lrclk and sdata SHALL take the values for the new bit count.
REQ-014 A frame SHALL be 64 bclk: bit count 0..31 is the left slot, 32..63 the right slot; lrclk = bit count bit 5.
REQ-015 Within a slot at position p (0..31), sdata SHALL be sample bit W-p for 1 <= p <= W (MSB first, one bclk after lrclk change); otherwise 0.
REQ-016 Lane k's left sample SHALL be (data_source + k) mod 2^W, and its right sample SHALL be the bitwise inverse of the left sample.
REQ-017 Samples SHALL be derived from the data_source value held during the frame; data_source SHALL increment by 1, wrapping 2^W-1 -> 0, on the falling edge where the bit count wraps 63 -> 0.
REQ-018 bclk and lrclk SHALL change only on clk edges; data and lrclk SHALL never change on a bclk rising edge, so a receiver samples on the rising edge.

Reset
REQ-019 While rst_n = 0, the outputs SHALL be: divider = 0, bclk = 0, bit count = 0, lrclk = 0, sdata = 0, data_source = 0, asynchronously.
REQ-020 After rst_n rises, the first bclk rising toggle SHALL occur on clk edge BCLK_DIV/2 and the first falling toggle on edge BCLK_DIV.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately; after release, output SHALL restart at frame 0 with data_source = 0.

Verification (N=2, W=24, BCLK_DIV=4)
REQ-022 Release reset -> bclk rises at clk edge 2, falls at edge 4; period 4 clk; lrclk = 0 and sdata = 0 until the first falling edge.
REQ-023 Deserialise frame 0 on bclk rising edges -> lane0 left = 0x000000, right = 0xFFFFFF; lane1 left = 0x000001, right = 0xFFFFFE; slot bits 25..31 = 0.
REQ-024 Count clk edges after release -> data_source becomes 1 at edge 256 (64 falling edges); frame 1 lane0 left = 0x000001.
REQ-025 Force data_source to 0xFFFFFF via a long run or a small-W variant (W=4: 15 -> 0) -> lane1 left wraps to 0x000000, and data_source wraps to 0.
REQ-026 Assert rst_n = 0 at bit count 40 -> all outputs drop to 0 at once; after release, frame 0 is reproduced exactly as in REQ-023.
REQ-027 Check lrclk transitions -> each occurs on a bclk falling edge, exactly one bclk before the slot MSB; 32 bclk high and 32 bclk low per frame.

Source files
------------

// File: rtl/myip_i2s_sender_v1_0.sv
// Multi-lane I2S test-pattern sender: all lanes share bclk/lrclk; lane k sends
// left = data_source + k and right = ~left, MSB one bclk after each lrclk change.
module myip_i2s_sender_v1_0 #(
  parameter int I2S_RECEIVER_NUM           = 16,
  parameter int I2S_SENDER_TEST_DATA_WIDTH = 24,
  parameter int BCLK_DIV                   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  output logic [I2S_RECEIVER_NUM-1:0]           i2s_sender_bclk,
  output logic [I2S_RECEIVER_NUM-1:0]           i2s_sender_lrclk,
  output logic [I2S_RECEIVER_NUM-1:0]           i2s_sender_sdata,
  output logic [I2S_SENDER_TEST_DATA_WIDTH-1:0] data_source
);
  localparam int N    = I2S_RECEIVER_NUM;
  localparam int W    = I2S_SENDER_TEST_DATA_WIDTH;
  localparam int HALF = BCLK_DIV / 2;
  localparam int DIVW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DIVW-1:0] r_div;
  logic            r_bclk;
  logic            r_lrclk;
  logic [5:0]      r_bit_cnt;
  logic [N-1:0]    r_sdata;
  logic [W-1:0]    r_data_source;

  logic            w_div_tc;
  logic            w_bclk_fall;
  logic [5:0]      w_cnt_next;
  logic [4:0]      w_pos;
  logic            w_pos_active;
  logic [N-1:0]    w_sdata_next;

  assign w_div_tc     = (r_div == DIVW'(HALF - 1));
  assign w_bclk_fall  = w_div_tc & r_bclk;
  assign w_cnt_next   = r_bit_cnt + 6'd1;
  assign w_pos        = w_cnt_next[4:0];
  assign w_pos_active = (w_pos != 5'd0) && ({27'd0, w_pos} <= 32'(W));

  // Next sdata is computed for the bit count being entered, so it changes
  // together with lrclk on the bclk falling edge.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [W-1:0] w_left;
    logic [W-1:0] w_sample;
    logic [W-1:0] w_shifted;
    assign w_left            = r_data_source + W'(k);
    assign w_sample          = w_cnt_next[5] ? ~w_left : w_left;
    assign w_shifted         = w_sample >> (5'(W) - w_pos);
    assign w_sdata_next[k]   = w_pos_active & w_shifted[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_bit_cnt     <= '0;
      r_sdata       <= '0;
      r_data_source <= '0;
    end else begin
      r_div <= w_div_tc ? '0 : r_div + DIVW'(1);
      if (w_div_tc) r_bclk <= ~r_bclk;
      if (w_bclk_fall) begin
        r_bit_cnt <= w_cnt_next;
        r_lrclk   <= w_cnt_next[5];
        r_sdata   <= w_sdata_next;
        if (r_bit_cnt == 6'd63) r_data_source <= r_data_source + W'(1);
      end
    end
  end

  assign i2s_sender_bclk  = {N{r_bclk}};
  assign i2s_sender_lrclk = {N{r_lrclk}};
  assign i2s_sender_sdata = r_sdata;
  assign data_source      = r_data_source;

endmodule

// File: tb/tb_myip_i2s_sender_v1_0.sv
// Bench for myip_i2s_sender_v1_0: scoreboard of per-slot samples for a 2-lane
// 24-bit instance, plus a 4-bit instance used to reach the data_source wrap.
module tb_myip_i2s_sender_v1_0;
  localparam int N  = 2;
  localparam int W  = 24;
  localparam int W2 = 4;
  typedef logic [N-1:0][W-1:0] slot_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rst2_n = 1'b0;
  logic [N-1:0]  bclk, lrclk, sdata;
  logic [N-1:0]  bclk2, lrclk2, sdata2;
  logic [W-1:0]  ds;
  logic [W2-1:0] ds2;
  int            cyc, cyc2;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            done2 = 1'b0;
  slot_t         sb_q[$];

  always #5 clk = ~clk;

  myip_i2s_sender_v1_0 #(.I2S_RECEIVER_NUM(N), .I2S_SENDER_TEST_DATA_WIDTH(W), .BCLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .i2s_sender_bclk(bclk), .i2s_sender_lrclk(lrclk),
    .i2s_sender_sdata(sdata), .data_source(ds));

  myip_i2s_sender_v1_0 #(.I2S_RECEIVER_NUM(N), .I2S_SENDER_TEST_DATA_WIDTH(W2), .BCLK_DIV(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .i2s_sender_bclk(bclk2), .i2s_sender_lrclk(lrclk2),
    .i2s_sender_sdata(sdata2), .data_source(ds2));

  // clk edges since reset release; at the negedge after edge e the count reads e
  always @(posedge clk or negedge rst_n)  if (!rst_n)  cyc  <= 0; else cyc  <= cyc + 1;
  always @(posedge clk or negedge rst2_n) if (!rst2_n) cyc2 <= 0; else cyc2 <= cyc2 + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input bit sel, input int e);
    int budget = 0;
    @(negedge clk);
    while ((sel ? cyc2 : cyc) != e && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if ((sel ? cyc2 : cyc) != e) chk("wait_timeout", 64'(sel ? cyc2 : cyc), 64'(e));
  endtask

  function automatic slot_t mk_slot(input logic [W-1:0] d, input bit right);
    slot_t s;
    for (int k = 0; k < N; k++) begin
      s[k] = d + W'(k);
      if (right) s[k] = ~s[k];
    end
    return s;
  endfunction

  // Monitor: deserialise on each bclk rise, pop the expected slot when it ends.
  logic [5:0] mpos;
  slot_t      acc, exp_s;
  logic       prev_bclk;
  int         slot_no = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mpos      = '0;
      acc       = '0;
      prev_bclk = 1'b0;
    end else begin
      if (bclk[0] && !prev_bclk) begin
        chk("bclk_lanes", bclk, {N{1'b1}});
        chk($sformatf("lrclk_pos%0d", mpos), lrclk, {N{mpos[5]}});
        if (mpos[4:0] >= 5'd1 && mpos[4:0] <= W) begin
          for (int k = 0; k < N; k++) acc[k] = {acc[k][W-2:0], sdata[k]};
        end else begin
          chk($sformatf("pad_bit_pos%0d", mpos), sdata, '0);
        end
        if (mpos[4:0] == 5'd31) begin
          if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
          else begin
            exp_s = sb_q.pop_front();
            for (int k = 0; k < N; k++)
              chk($sformatf("slot%0d_lane%0d", slot_no, k), acc[k], exp_s[k]);
          end
          slot_no++;
        end
        mpos = mpos + 6'd1;
      end
      prev_bclk = bclk[0];
    end
  end

  // Small-width instance: data_source wraps 15 -> 0 and lane1 left wraps to 0.
  initial begin
    logic [W2-1:0] l0, l1, r0, r1;
    l0 = '0; l1 = '0; r0 = '0; r1 = '0;
    wait (rst2_n === 1'b1);
    wait_cyc(1, 3839);
    chk("w4_ds_before", ds2, 4'd14);
    wait_cyc(1, 3840);
    chk("w4_ds_15", ds2, 4'd15);
    for (int j = 1; j <= W2; j++) begin
      wait_cyc(1, 3842 + 4 * j);
      l0 = {l0[W2-2:0], sdata2[0]};
      l1 = {l1[W2-2:0], sdata2[1]};
    end
    for (int j = 33; j <= 32 + W2; j++) begin
      wait_cyc(1, 3842 + 4 * j);
      r0 = {r0[W2-2:0], sdata2[0]};
      r1 = {r1[W2-2:0], sdata2[1]};
    end
    chk("w4_lane0_left", l0, 4'hF);
    chk("w4_lane1_left", l1, 4'h0);
    chk("w4_lane0_right", r0, 4'h0);
    chk("w4_lane1_right", r1, 4'hF);
    wait_cyc(1, 4095);
    chk("w4_ds_last", ds2, 4'd15);
    wait_cyc(1, 4096);
    chk("w4_ds_wrap", ds2, 4'd0);
    done2 = 1'b1;
  end

  initial begin
    int budget;
    repeat (3) @(negedge clk);
    chk("rst_bclk", bclk, '0);
    chk("rst_lrclk", lrclk, '0);
    chk("rst_sdata", sdata, '0);
    chk("rst_ds", ds, '0);
    chk("rst_ds2", ds2, '0);

    sb_q.push_back({24'h000001, 24'h000000});
    sb_q.push_back({24'hFFFFFE, 24'hFFFFFF});
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;

    wait_cyc(0, 1); chk("bclk_e1", bclk, 2'b00);
    wait_cyc(0, 2); chk("bclk_e2", bclk, 2'b11);
    wait_cyc(0, 3);
    chk("bclk_e3", bclk, 2'b11);
    chk("lrclk_pre_fall", lrclk, 2'b00);
    chk("sdata_pre_fall", sdata, 2'b00);
    wait_cyc(0, 4); chk("bclk_e4", bclk, 2'b00);
    wait_cyc(0, 6); chk("bclk_e6", bclk, 2'b11);
    wait_cyc(0, 8); chk("bclk_e8", bclk, 2'b00);
    wait_cyc(0, 127); chk("lrclk_e127", lrclk, 2'b00);
    wait_cyc(0, 128); chk("lrclk_e128", lrclk, 2'b11);
    wait_cyc(0, 255);
    chk("ds_e255", ds, 24'd0);
    chk("lrclk_e255", lrclk, 2'b11);
    wait_cyc(0, 256);
    chk("ds_e256", ds, 24'd1);
    chk("lrclk_e256", lrclk, 2'b00);
    sb_q.push_back(mk_slot(24'd1, 1'b0));
    sb_q.push_back(mk_slot(24'd1, 1'b1));
    sb_q.push_back(mk_slot(24'd2, 1'b0));

    // Frame 2, bit count 40, bclk high: abort with reset
    wait_cyc(0, 674);
    #2;
    chk("mid_bclk", bclk, 2'b11);
    chk("mid_lrclk", lrclk, 2'b11);
    chk("mid_sdata", sdata, 2'b11);
    chk("mid_ds", ds, 24'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_bclk", bclk, '0);
    chk("abort_lrclk", lrclk, '0);
    chk("abort_sdata", sdata, '0);
    chk("abort_ds", ds, '0);

    sb_q.push_back({24'h000001, 24'h000000});
    sb_q.push_back({24'hFFFFFE, 24'hFFFFFF});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(0, 2); chk("re_bclk_e2", bclk, 2'b11);
    wait_cyc(0, 4); chk("re_bclk_e4", bclk, 2'b00);
    wait_cyc(0, 260);
    chk("re_ds", ds, 24'd1);
    rst_n = 1'b0;

    budget = 0;
    while (!done2 && budget < 6000) begin
      @(negedge clk);
      budget++;
    end
    chk("w4_done", 64'(done2), 64'd1);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
